ps2_key_sender: RTL and testbench
=================================

# ps2_key_sender

Device-side PS/2 keyboard transmitter: the other end of the keyboard receive path that feeds the seven-segment scan-code/ASCII/count display. It accepts one key event per handshake (scan code plus extended/release flags), expands it into the set-2 byte sequence (optional E0, optional F0, code), and serialises each byte as an 11-bit PS/2 frame on open-drain-style `ps2_clk`/`ps2_data` outputs. Used as a keyboard model driving the receiver in simulation and as a loopback source on the board. It also counts completed events for the count display.

## Interface
- `CLK_DIV`, 2500: system cycles per PS/2 clock half-period (10 kHz at 50 MHz); must be ≥ 2.
- `GAP_CYCLES`, 10000: idle cycles, both lines high, after every frame; must be ≥ 1.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_valid` in 1: event request.
- `key_ready` out 1: high only in IDLE; the event is accepted when `key_valid & key_ready`.
- `key_code` in 8: set-2 scan code, latched on accept.
- `key_ext` in 1: prepend E0, latched on accept.
- `key_release` in 1: insert F0 before code, latched on accept.
- `ps2_clk` out 1: PS/2 clock, idle 1.
- `ps2_data` out 1: PS/2 data, idle 1.
- `busy` out 1: equals `~key_ready`.
- `sent_count` out 8: completed events, modulo 256.

## Operation
- Reset values: `ps2_clk`=1, `ps2_data`=1, `key_ready`=1, `busy`=0, `sent_count`=0, FSM=IDLE, all counters 0.
- Byte order per event: E0 (if `key_ext`), F0 (if `key_release`), then `key_code`. There are 1 to 3 bytes.
- Frame bits: start 0, data[0]..data[7] LSB first, odd parity (`~^data`), stop 1.
- Top FSM states and transitions:
  - IDLE -> FRAME on accept.
  - FRAME -> GAP after the stop bit completes.
  - GAP -> FRAME if bytes remain, otherwise -> IDLE.
- On GAP -> IDLE: `sent_count` increments by 1 in the same cycle, wrapping FF -> 00.
- `key_valid` while not ready is ignored. There is no queue, and the inputs are not re-sampled mid-event.
- Reset mid-event abandons the event immediately. No partial frame completion is attempted.

## Timing
- Accept at rising edge N. Edge N+1: FSM=FRAME, `ps2_data`=0 (start), `ps2_clk`=1, `key_ready`=0.
- Each bit lasts 2·`CLK_DIV` cycles:
  - `ps2_data` changes only on the edge where `ps2_clk` rises, or on frame entry.
  - `ps2_clk` stays high for `CLK_DIV` cycles, then low for `CLK_DIV` cycles.
  - The receiver samples on the falling edge.
- First `ps2_clk` fall at edge N+1+`CLK_DIV`. Bit k (k = 0 start … 10 stop) is valid from edge N+1+2k·`CLK_DIV`.
- Frame ends at edge N+1+22·`CLK_DIV`: `ps2_clk` high, `ps2_data` high, GAP entered. GAP lasts exactly `GAP_CYCLES` cycles.
- One-byte event: `key_ready` returns high at edge N+1+22·`CLK_DIV`+`GAP_CYCLES`, and `sent_count` updates on that same edge.
- Each extra byte adds 22·`CLK_DIV`+`GAP_CYCLES` cycles.
- Divider counter width: `$clog2(max(CLK_DIV, GAP_CYCLES))`. Bit counter: 4 bits (0..10). Byte counter: 2 bits.
- `rst` high at edge M: every output is at its reset value from edge M onward. The earliest new accept is at edge M+1.

## Structure
- Package `ps2_pkg`:
  - `PS2_EXT_PREFIX` = 8'hE0.
  - `PS2_BREAK_PREFIX` = 8'hF0.
  - `PS2_FRAME_BITS` = 11.
  - Top FSM state enum (IDLE, FRAME, GAP).
- Sub-module `ps2_frame_tx` serialises one byte:
  - Inputs: `start` pulse and `byte_in`.
  - Outputs: `ps2_clk`, `ps2_data`, `done` pulse on the stop-bit end.
  - Owns the half-period divider and the bit counter.
- `ps2_key_sender` owns the byte-sequence latch, the GAP timer, the handshake, and `sent_count`.

## Test plan
All scenarios use `CLK_DIV`=4, `GAP_CYCLES`=8, with a bench sampler that captures bits on falling edges.
- Make 8'h1C, ext=0, rel=0:
  - One frame with bits 0, 0,0,1,1,1,0,0,0, parity 0, stop 1.
  - `key_ready` high again 97 cycles after entry (edge N+97).
  - `sent_count`=1.
- Release 8'h1C: frames F0 (parity 1) then 1C (parity 0). `sent_count` increments once only.
- Extended release 8'h75: frames E0, F0, 75 in that order with parities 0, 1, 0. `busy` stays high for all 3·96 cycles.
- `key_valid` pulsed with 8'h2A during the first frame:
  - The request is ignored and no extra frame appears.
  - `sent_count` rises by 1 only.
- `rst` at bit 5 of a frame:
  - Next cycle: `ps2_clk`=1, `ps2_data`=1, `key_ready`=1, `sent_count`=0.
  - A following 8'h00 request sends a clean frame with parity 1.
- 256 back-to-back make events: `sent_count` wraps FF -> 00 on the 256th completion.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, top-level state type and byte-sequence helpers
// for the PS/2 keyboard transmitter (ps2_key_sender / ps2_frame_tx).
//
// Contents:
//   PS2_EXT_PREFIX, PS2_BREAK_PREFIX : set-2 prefix bytes
//   PS2_FRAME_BITS, PS2_STOP_BIT_IDX : frame geometry (start, 8 data, parity, stop)
//   ps2_state_t                      : top FSM states
//   odd_parity / seq_len / seq_byte  : frame parity and event-to-byte expansion
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam int         PS2_FRAME_BITS   = 11;
  localparam logic [3:0] PS2_STOP_BIT_IDX = 4'(PS2_FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2
  } ps2_state_t;

  // Parity bit that makes the total number of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Number of bytes an event expands to (1..3).
  function automatic logic [1:0] seq_len(input logic ext, input logic rel);
    return 2'd1 + {1'b0, ext} + {1'b0, rel};
  endfunction

  // Byte at position idx of the sequence: [E0] [F0] code.
  function automatic logic [7:0] seq_byte(input logic       ext,
                                          input logic       rel,
                                          input logic [7:0] code,
                                          input logic [1:0] idx);
    logic [7:0] b;
    b = code;
    case (idx)
      2'd0: begin
        if (ext) begin
          b = PS2_EXT_PREFIX;
        end else if (rel) begin
          b = PS2_BREAK_PREFIX;
        end else begin
          b = code;
        end
      end
      2'd1: begin
        // Second byte is only a prefix when both prefixes are present.
        if (ext && rel) begin
          b = PS2_BREAK_PREFIX;
        end else begin
          b = code;
        end
      end
      default: b = code;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// ps2_frame_tx: serialises one byte as an 11-bit PS/2 device-to-host frame.
//
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   start      : one-cycle pulse; loads byte_in and begins the frame on this edge
//   byte_in    : byte to send (sampled with start)
//   ps2_clk    : PS/2 clock (idle 1), high CLK_DIV cycles then low CLK_DIV per bit
//   ps2_data   : PS/2 data (idle 1), changes only when ps2_clk rises or on start
//   done       : strobe in the last cycle of the stop bit; the frame ends on the
//                following edge, so a parent FSM can change state on that same edge
module ps2_frame_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 2500,
  parameter int CNT_W   = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       done
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             active_r;
  logic [CNT_W-1:0] div_r;
  logic [3:0]       bit_r;
  // Bits still to go out after the start bit: data LSB first, parity, stop.
  logic [9:0]       shift_r;
  logic             half_end_s;

  assign half_end_s = active_r && (div_r == HALF_LAST);
  assign done       = half_end_s && !ps2_clk && (bit_r == PS2_STOP_BIT_IDX);

  // Half-period divider, bit counter and registered line drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_r <= 1'b0;
      div_r    <= {CNT_W{1'b0}};
      bit_r    <= 4'd0;
      shift_r  <= 10'h3FF;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end else if (start) begin
      active_r <= 1'b1;
      div_r    <= {CNT_W{1'b0}};
      bit_r    <= 4'd0;
      shift_r  <= {1'b1, odd_parity(byte_in), byte_in};
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b0;
    end else if (half_end_s) begin
      div_r <= {CNT_W{1'b0}};
      if (ps2_clk) begin
        ps2_clk <= 1'b0;
      end else begin
        // End of the low half: the clock rises and the next bit is presented.
        ps2_clk <= 1'b1;
        if (bit_r == PS2_STOP_BIT_IDX) begin
          active_r <= 1'b0;
          bit_r    <= 4'd0;
          ps2_data <= 1'b1;
        end else begin
          bit_r    <= bit_r + 4'd1;
          ps2_data <= shift_r[0];
          shift_r  <= {1'b1, shift_r[9:1]};
        end
      end
    end else if (active_r) begin
      div_r <= div_r + CNT_ONE;
    end else begin
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_sender.sv
// ps2_key_sender: device-side PS/2 keyboard transmitter.
//
// Accepts one key event per valid/ready handshake, expands it into the set-2
// byte sequence ([E0] [F0] code) and sends each byte as a PS/2 frame followed
// by an idle gap of GAP_CYCLES with both lines high. Counts completed events.
//
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   key_valid    : event request
//   key_ready    : high only while idle; event accepted on key_valid & key_ready
//   key_code     : set-2 scan code (latched on accept)
//   key_ext      : prepend E0 (latched on accept)
//   key_release  : insert F0 before the code (latched on accept)
//   ps2_clk      : PS/2 clock, idle 1
//   ps2_data     : PS/2 data, idle 1
//   busy         : ~key_ready
//   sent_count   : completed events, modulo 256
module ps2_key_sender
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 2500,
  parameter int GAP_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [7:0] key_code,
  input  logic       key_ext,
  input  logic       key_release,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic [7:0] sent_count
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ps2_state_t       state_r;
  ps2_state_t       state_next;
  logic [7:0]       code_r;
  logic             ext_r;
  logic             rel_r;
  logic [1:0]       len_r;
  logic [1:0]       byte_cnt_r;
  logic [CNT_W-1:0] gap_cnt_r;
  logic             key_ready_r;
  logic             busy_r;
  logic [7:0]       sent_count_r;

  logic             accept_s;
  logic             more_s;
  logic             gap_end_s;
  logic             start_s;
  logic [7:0]       byte_sel_s;
  logic             advance_s;
  logic             count_inc_s;
  logic             tx_done_s;

  assign accept_s   = key_valid && key_ready_r;
  assign more_s     = (byte_cnt_r != (len_r - 2'd1));
  assign gap_end_s  = (gap_cnt_r == GAP_LAST);

  assign key_ready  = key_ready_r;
  assign busy       = busy_r;
  assign sent_count = sent_count_r;

  ps2_frame_tx #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_frame_tx (
    .clk      (clk),
    .rst      (rst),
    .start    (start_s),
    .byte_in  (byte_sel_s),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .done     (tx_done_s)
  );

  // Next-state logic; also picks the byte handed to the serialiser.
  always_comb begin
    state_next  = state_r;
    start_s     = 1'b0;
    byte_sel_s  = seq_byte(key_ext, key_release, key_code, 2'd0);
    advance_s   = 1'b0;
    count_inc_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          // First byte comes straight from the inputs so the frame starts
          // on the accepting edge.
          state_next = FRAME;
          start_s    = 1'b1;
          byte_sel_s = seq_byte(key_ext, key_release, key_code, 2'd0);
        end else begin
          state_next = IDLE;
        end
      end
      FRAME: begin
        if (tx_done_s) begin
          state_next = GAP;
        end else begin
          state_next = FRAME;
        end
      end
      GAP: begin
        if (gap_end_s) begin
          if (more_s) begin
            state_next = FRAME;
            start_s    = 1'b1;
            advance_s  = 1'b1;
            byte_sel_s = seq_byte(ext_r, rel_r, code_r, byte_cnt_r + 2'd1);
          end else begin
            state_next  = IDLE;
            count_inc_s = 1'b1;
          end
        end else begin
          state_next = GAP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register, event latch, gap timer, handshake and event counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      code_r       <= 8'h00;
      ext_r        <= 1'b0;
      rel_r        <= 1'b0;
      len_r        <= 2'd1;
      byte_cnt_r   <= 2'd0;
      gap_cnt_r    <= {CNT_W{1'b0}};
      key_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      sent_count_r <= 8'h00;
    end else begin
      state_r     <= state_next;
      key_ready_r <= (state_next == IDLE);
      busy_r      <= (state_next != IDLE);

      if (accept_s) begin
        code_r     <= key_code;
        ext_r      <= key_ext;
        rel_r      <= key_release;
        len_r      <= seq_len(key_ext, key_release);
        byte_cnt_r <= 2'd0;
      end else if (advance_s) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
      end else begin
        byte_cnt_r <= byte_cnt_r;
      end

      // Timer restarts from zero on every GAP entry.
      if ((state_r == GAP) && (state_next == GAP)) begin
        gap_cnt_r <= gap_cnt_r + CNT_ONE;
      end else begin
        gap_cnt_r <= {CNT_W{1'b0}};
      end

      if (count_inc_s) begin
        sent_count_r <= sent_count_r + 8'd1;
      end else begin
        sent_count_r <= sent_count_r;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_sender.sv
// tb_ps2_key_sender: self-checking bench for ps2_key_sender (CLK_DIV=4,
// GAP_CYCLES=8). A timing model derived from event entry time predicts every
// output each cycle; a falling-edge sampler captures frames for literal checks.
module tb_ps2_key_sender;

  localparam int CLK_DIV    = 4;
  localparam int GAP_CYCLES = 8;
  localparam int BIT_CYC    = 2 * CLK_DIV;
  localparam int FRAME_CYC  = 22 * CLK_DIV;
  localparam int BYTE_CYC   = FRAME_CYC + GAP_CYCLES;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       key_ext = 1'b0;
  logic       key_release = 1'b0;
  logic       key_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [7:0] sent_count;

  ps2_key_sender #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_release (key_release),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .busy        (busy),
    .sent_count  (sent_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Receiver-style sampler: data captured on every falling ps2_clk.
  logic bits_q[$];
  always @(negedge ps2_clk) begin
    if (rst === 1'b0) bits_q.push_back(ps2_data);
  end

  // Inputs as seen by the DUT at each rising edge; cyc = index of last edge.
  int         cyc = 0;
  logic       smp_rst, smp_valid, smp_ext, smp_rel;
  logic [7:0] smp_code;
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    smp_rst   <= rst;
    smp_valid <= key_valid;
    smp_ext   <= key_ext;
    smp_rel   <= key_release;
    smp_code  <= key_code;
  end

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9) return ~^b;
    return 1'b1;
  endfunction

  // Behavioural model: event = list of bytes, each occupying BYTE_CYC cycles
  // from its entry edge; outputs follow from the offset into that list.
  bit         m_on = 1'b0;
  bit         m_active = 1'b0;
  int         m_entry, m_n, m_count, m_o, m_b, m_r;
  logic [7:0] m_bytes [3];
  logic       e_clk, e_data, e_ready, e_busy;
  initial begin
    forever begin
      @(negedge clk);
      if (smp_rst === 1'b1) begin
        m_on = 1'b1;
        m_active = 1'b0;
        m_count = 0;
      end else if (m_on) begin
        if (m_active) begin
          if (cyc - m_entry == m_n * BYTE_CYC) begin
            m_active = 1'b0;
            m_count = (m_count + 1) % 256;
          end
        end else if (smp_valid === 1'b1) begin
          m_active = 1'b1;
          m_entry = cyc;
          m_n = 0;
          if (smp_ext) begin m_bytes[m_n] = 8'hE0; m_n = m_n + 1; end
          if (smp_rel) begin m_bytes[m_n] = 8'hF0; m_n = m_n + 1; end
          m_bytes[m_n] = smp_code;
          m_n = m_n + 1;
        end
      end
      if (m_on) begin
        if (m_active) begin
          m_o = cyc - m_entry;
          m_b = m_o / BYTE_CYC;
          m_r = m_o % BYTE_CYC;
          if (m_r < FRAME_CYC) begin
            e_clk  = ((m_r % BIT_CYC) < CLK_DIV);
            e_data = frame_bit(m_bytes[m_b], m_r / BIT_CYC);
          end else begin
            e_clk  = 1'b1;
            e_data = 1'b1;
          end
          e_ready = 1'b0;
          e_busy  = 1'b1;
        end else begin
          e_clk   = 1'b1;
          e_data  = 1'b1;
          e_ready = 1'b1;
          e_busy  = 1'b0;
        end
        chk("cycle{clk,data,ready,busy,count}",
            {20'd0, ps2_clk, ps2_data, key_ready, busy, sent_count},
            {20'd0, e_clk, e_data, e_ready, e_busy, 8'(m_count)});
      end
    end
  end

  // Waits (bounded) at falling clock edges for busy or key_ready to be 1.
  task automatic wait_sig(input bit want_ready, input int bound);
    int n = 0;
    while ((((want_ready ? key_ready : busy)) !== 1'b1) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    if (want_ready) chk("wait_ready", key_ready, 1);
    else            chk("wait_busy", busy, 1);
  endtask

  task automatic start_event(input logic [7:0] code, input logic ext, input logic rel);
    key_code    = code;
    key_ext     = ext;
    key_release = rel;
    key_valid   = 1'b1;
    wait_sig(1'b0, 20);
    key_valid = 1'b0;
  endtask

  // Full event; returns number of cycles busy was high. With noise, random
  // requests are thrown at the DUT while it is busy (they must be ignored).
  task automatic run_event(input logic [7:0] code, input logic ext, input logic rel,
                           input bit noise, output int bc);
    start_event(code, ext, rel);
    bc = 1;
    while ((key_ready !== 1'b1) && (bc < 400)) begin
      if (noise) begin
        key_valid   = ($urandom_range(0, 5) == 0);
        key_code    = 8'($urandom);
        key_ext     = 1'($urandom);
        key_release = 1'($urandom);
      end
      @(negedge clk);
      if (busy === 1'b1) bc++;
    end
    key_valid = 1'b0;
    chk("event_done", key_ready, 1);
  endtask

  // Captured frames packed as {stop, parity, data[7:0], start}.
  task automatic check_frames(input int n, input logic [10:0] f0,
                              input logic [10:0] f1, input logic [10:0] f2);
    logic [10:0] exp_f [3];
    logic [10:0] got;
    exp_f[0] = f0; exp_f[1] = f1; exp_f[2] = f2;
    chk("frame_bit_count", bits_q.size(), n * 11);
    for (int i = 0; (i < n) && ((i * 11 + 10) < bits_q.size()); i++) begin
      for (int k = 0; k < 11; k++) got[k] = bits_q[i * 11 + k];
      chk($sformatf("frame%0d", i), {21'd0, got}, {21'd0, exp_f[i]});
    end
    bits_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int bc;

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_ps2_clk", ps2_clk, 1);
    chk("rst_ps2_data", ps2_data, 1);
    chk("rst_key_ready", key_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sent_count", sent_count, 0);
    rst = 1'b0;
    bits_q.delete();
    @(negedge clk);

    // Make 1C: one frame, 96 cycles busy.
    run_event(8'h1C, 1'b0, 1'b0, 1'b0, bc);
    chk("make_busy_cycles", bc, 96);
    check_frames(1, 11'h438, 11'h000, 11'h000);
    chk("make_count", sent_count, 1);

    // Release 1C: F0 then 1C, single count.
    run_event(8'h1C, 1'b0, 1'b1, 1'b0, bc);
    chk("release_busy_cycles", bc, 192);
    check_frames(2, 11'h7E0, 11'h438, 11'h000);
    chk("release_count", sent_count, 2);

    // Extended release 75: E0, F0, 75.
    run_event(8'h75, 1'b1, 1'b1, 1'b0, bc);
    chk("ext_release_busy_cycles", bc, 288);
    check_frames(3, 11'h5C0, 11'h7E0, 11'h4EA);
    chk("ext_release_count", sent_count, 3);

    // Request for 2A during the first frame is ignored.
    start_event(8'h1C, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    key_code  = 8'h2A;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    wait_sig(1'b1, 200);
    repeat (3) @(negedge clk);
    check_frames(1, 11'h438, 11'h000, 11'h000);
    chk("ignored_req_count", sent_count, 4);

    // Reset at bit 5 of a frame, then a clean 00 frame.
    start_event(8'h1C, 1'b0, 1'b0);
    repeat (5 * BIT_CYC) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ps2_clk", ps2_clk, 1);
    chk("midrst_ps2_data", ps2_data, 1);
    chk("midrst_key_ready", key_ready, 1);
    chk("midrst_sent_count", sent_count, 0);
    rst = 1'b0;
    bits_q.delete();
    run_event(8'h00, 1'b0, 1'b0, 1'b0, bc);
    check_frames(1, 11'h600, 11'h000, 11'h000);
    chk("after_rst_count", sent_count, 1);

    // Randomised events with random spacing and ignored requests while busy.
    for (int i = 0; i < 30; i++) begin
      run_event(8'($urandom), 1'($urandom), 1'($urandom), 1'b1, bc);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    // 256 back-to-back make events: counter wraps to 00 on the last one.
    do_reset();
    key_code    = 8'($urandom);
    key_ext     = 1'b0;
    key_release = 1'b0;
    key_valid   = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      wait_sig(1'b0, 20);
      wait_sig(1'b1, 200);
      if (i == 255) chk("wrap_count_255", sent_count, 8'd255);
      if (i == 256) chk("wrap_count_256", sent_count, 8'd0);
    end
    key_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
